// File: rtl/alu_reg_ctrl_pkg.sv
// alu_ctrl_pkg: shared widths, sequencer states and flag bit positions
package alu_ctrl_pkg;
  localparam int DW = 32;
  localparam int OPW = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXEC = 2'd2, RESP = 2'd3} state_t;
  localparam int ZF = 3;
  localparam int CF = 2;
  localparam int OF = 1;
  localparam int SF = 0;
endpackage

// File: rtl/alu_reg_ctrl_if.sv
// alu_reg_ctrl_if: request, datapath-control and response signals of the ALU sequencer
//   slave  : the sequencer (takes requests and f/fr, drives strobes and responses)
//   master : requesters, datapath and response consumer
interface alu_reg_ctrl_if import alu_ctrl_pkg::*; ();
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*OPW-1:0] req_op;
  logic [2*DW-1:0]  req_a;
  logic [2*DW-1:0]  req_b;
  logic [OPW-1:0]   alu_op;
  logic [DW-1:0]    data_a;
  logic [DW-1:0]    data_b;
  logic             ld_rr;
  logic             ld_f;
  logic [DW-1:0]    f;
  logic [3:0]       fr;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [DW-1:0]    resp_f;
  logic [3:0]       resp_fr;
  logic             busy;
  modport slave (
    input  req_valid, req_op, req_a, req_b, f, fr, resp_ready,
    output req_ready, alu_op, data_a, data_b, ld_rr, ld_f, resp_valid, resp_id, resp_f, resp_fr, busy
  );
  modport master (
    output req_valid, req_op, req_a, req_b, f, fr, resp_ready,
    input  req_ready, alu_op, data_a, data_b, ld_rr, ld_f, resp_valid, resp_id, resp_f, resp_fr, busy
  );
endinterface

// File: rtl/alu_reg_ctrl_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter
//   req  : request vector      en   : grant permitted this cycle
//   last : previous grant index gnt  : one-hot grant   idx : grant index
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       idx
);
  assign idx = &req ? ~last : req[1];
  assign gnt = (en && |req) ? (idx ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/alu_reg_ctrl.sv
// alu_reg_ctrl: round-robin sequencer sharing the registered ALU datapath between two requesters
//   clk, rst : clock and asynchronous active-high reset
//   bus      : requests in, operand/opcode/load strobes out, f/fr in, response out
module alu_reg_ctrl import alu_ctrl_pkg::*; (
  input logic clk,
  input logic rst,
  alu_reg_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_RESP = RESP;
  logic [1:0]     state, nxt;
  logic           last, id, gidx;
  logic [1:0]     gnt;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  a_q, b_q;
  // rst gates the grant so req_ready reads 0 while reset is held
  rr_arb2 u_arb (.req(bus.req_valid), .en(state == S_IDLE && !rst), .last(last), .gnt(gnt), .idx(gidx));
  always_comb begin
    nxt = state == S_IDLE ? (|gnt ? S_LOAD : S_IDLE) :
          state == S_LOAD ? S_EXEC :
          state == S_EXEC ? S_RESP :
          (bus.resp_ready ? S_IDLE : S_RESP);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      last  <= 1'b1;
      id    <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= nxt;
      if (|gnt) begin
        last <= gidx;
        id   <= gidx;
        op_q <= gidx ? bus.req_op[2*OPW-1:OPW] : bus.req_op[OPW-1:0];
        a_q  <= gidx ? bus.req_a[2*DW-1:DW] : bus.req_a[DW-1:0];
        b_q  <= gidx ? bus.req_b[2*DW-1:DW] : bus.req_b[DW-1:0];
      end
    end
  end
  assign bus.req_ready  = gnt;
  assign bus.alu_op     = op_q;
  assign bus.data_a     = a_q;
  assign bus.data_b     = b_q;
  assign bus.ld_rr      = state == S_LOAD;
  assign bus.ld_f       = state == S_EXEC;
  assign bus.resp_valid = state == S_RESP;
  assign bus.resp_id    = id;
  assign bus.resp_f     = bus.f;
  assign bus.resp_fr    = bus.fr;
  assign bus.busy       = state != S_IDLE;
endmodule

// File: doc/alu_reg_ctrl.md
# alu_reg_ctrl

Single-clock sequencer that shares the registered ALU datapath (operand registers A/B, ALU, result register F, flag register FR) between two requesters. It arbitrates round-robin, drives the operands and opcode, pulses the operand-load and result-load strobes in order, and returns the registered result and flags through a valid/ready response channel. It sits between the instruction/test front ends and the ALU register datapath, replacing the two free-running capture clocks with explicit load enables.

## Interface

- DW, 32, operand/result width
- OPW, 4, ALU opcode width (opaque to this block, passed through)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; one-hot or zero
- req_op  in  2×OPW  per-requester opcode (req_op[i*OPW +: OPW])
- req_a  in  2×DW  per-requester operand A
- req_b  in  2×DW  per-requester operand B
- alu_op  out  OPW  opcode to ALU
- data_a  out  DW  to operand register A input
- data_b  out  DW  to operand register B input
- ld_rr  out  1  operand registers load enable
- ld_f  out  1  F/FR registers load enable
- f  in  DW  registered result from datapath
- fr  in  4  registered flags {ZF,CF,OF,SF}
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  1  requester index of response
- resp_f  out  DW  result
- resp_fr  out  4  flags {ZF,CF,OF,SF}
- busy  out  1  high in any state other than IDLE

## Operation

- FSM: IDLE → LOAD → EXEC → RESP → IDLE.
- IDLE: if any req_valid, grant one. req_ready[g]=1 combinationally for that cycle only. Capture op/a/b/id into internal registers. Next state LOAD.
- Arbitration is round-robin on last_grant:
  - Both valid: grant the index != last_grant.
  - One valid: grant it.
  - last_grant updates on grant only.
- LOAD: ld_rr=1 for exactly one cycle. data_a, data_b and alu_op are driven from the captured registers (held stable from LOAD through EXEC). Next state EXEC.
- EXEC: ld_f=1 for exactly one cycle. The ALU is combinational on the now-loaded A/B, so F/FR capture at the end of EXEC. Next state RESP.
- RESP:
  - resp_valid=1; resp_f=f, resp_fr=fr, resp_id=captured id. All held stable until the handshake.
  - resp_valid && resp_ready: go to IDLE.
  - No new grant in the handshake cycle.
- Requests are never accepted outside IDLE; req_ready=0 in LOAD/EXEC/RESP.
- The opcode is not decoded; any value is legal.

## Timing

- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first contention).
  - req_ready=0, ld_rr=0, ld_f=0, resp_valid=0, busy=0.
  - alu_op=0, data_a=0, data_b=0, resp_id=0.
  - resp_f and resp_fr follow f/fr, which are 0 when the datapath is under the same reset.
- Latency: accept in cycle 0, ld_rr in cycle 1, ld_f in cycle 2, resp_valid first high in cycle 3.
- Throughput: at most one operation per 4 cycles, with resp_ready tied high.
- resp_ready low stalls in RESP indefinitely. Outputs stay stable; pending requesters see req_ready=0.
- A requester dropping req_valid outside IDLE has no effect.
- A request accepted in IDLE is committed regardless of later inputs.
- rst asserted mid-operation: immediate return to reset values. The in-flight op is discarded with no response. The datapath must share rst.
- Simultaneous req_valid and response handshake: the response completes; the new request is granted in the following IDLE cycle.

## Structure

- Package alu_ctrl_pkg:
  - state enum (IDLE, LOAD, EXEC, RESP)
  - DW/OPW defaults
  - flag bit indices (ZF=3, CF=2, OF=1, SF=0)
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req[1:0], enable, last_grant register.
  - Outputs: one-hot grant and grant index.
- The FSM, capture registers and response mux live in alu_reg_ctrl.

## Test plan

- Single request: req 0, op=4'h1, a=32'h5, b=32'h7, resp_ready=1.
  - req_ready[0] in cycle 0; ld_rr in cycle 1 with data_a=5, data_b=7, alu_op=1; ld_f in cycle 2.
  - resp_valid in cycle 3 with resp_id=0 and resp_f/resp_fr equal to the datapath f/fr.
- Contention:
  - Both valid continuously from reset: grants alternate 0,1,0,1 over four ops, each response id matching.
  - Only req 1 valid: it is granted every time.
- Backpressure: resp_ready=0 for 5 cycles in RESP.
  - resp_valid and resp_f stable throughout; req_ready stays 0 with req 1 pending.
  - req 1 is granted in the first IDLE cycle after the handshake.
- Flags path: with the datapath model producing f=0, resp_fr[3]=1 (ZF). A subtract underflow case produces the model's SF/CF, returned unchanged.
- Reset mid-op: assert rst during EXEC.
  - All outputs return to reset values asynchronously; no response is produced.
  - After release, requester 0 wins against requester 1.
- Strobe exclusivity: across 100 random requests, ld_rr and ld_f are each one cycle per op, never high together, and never high in IDLE/RESP.
